// File: rtl/match_pkg.sv
// match_pkg: shared types, default constants and the saturating-increment helper
//   state_t         - turn FSM state encoding
//   HOLD_CYCLES_DEF - default match/not_match hold window
//   VAL_W_DEF       - default card value width
//   sat_inc()       - increment that sticks at the all-ones value of a w-bit counter
package match_pkg;

   typedef enum logic [1:0] {IDLE, HAVE_FIRST, SIGNAL} state_t;

   localparam int HOLD_CYCLES_DEF = 1000;
   localparam int VAL_W_DEF       = 4;

   function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned w);
      logic [31:0] max;
      max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (count >= max) ? count : count + 32'd1;
   endfunction

endpackage

// File: rtl/match_event_generator_hold_timer.sv
// hold_timer: loadable down-counter that stops at zero
//   clk, rst - clock, asynchronous active-high reset
//   load     - load value (has priority over en)
//   en       - count down by one while nonzero
//   value    - load value
//   zero     - counter currently reads 0
module hold_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst)
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;

   assign zero = (cnt == '0);

endmodule

// File: rtl/match_event_generator.sv
// match_event_generator: compares two card selections per turn and drives match/not_match for a hold window
//   clk, rst          - clock, asynchronous active-high reset
//   clear             - synchronous abort of the current turn (score counters kept)
//   sel_valid/ready   - selection handshake, sel_value carries the card value
//   match, not_match  - registered result, high for HOLD_CYCLES cycles per turn
//   busy              - a turn is in progress (HAVE_FIRST or SIGNAL)
//   pair_done         - one-cycle pulse on the first IDLE cycle after a completed hold window
//   hit_count         - saturating count of matches
//   miss_count        - saturating count of mismatches
module match_event_generator
   import match_pkg::*;
#(
   parameter int VAL_W       = VAL_W_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int CNT_W       = 20,
   parameter int SCORE_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               sel_valid,
   input  logic [VAL_W-1:0]   sel_value,
   output logic               sel_ready,
   output logic               match,
   output logic               not_match,
   output logic               busy,
   output logic               pair_done,
   output logic [SCORE_W-1:0] hit_count,
   output logic [SCORE_W-1:0] miss_count
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           state, state_n;
   logic [VAL_W-1:0] first_val;
   logic             eq_reg, eq_now, eq_sel;
   logic             xfer, second, hold_zero, done_n;

   hold_timer #(.CNT_W(CNT_W)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .load  (second),
      .en    (state == SIGNAL),
      .value (HOLD_LOAD),
      .zero  (hold_zero)
   );

   assign sel_ready = ~rst & (state != SIGNAL);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst)
      if (rst)
         state <= IDLE;
      else
         state <= state_n;

   // clear outranks any transfer, so a clear cycle never counts as a handshake
   always_comb begin
      xfer    = sel_valid & sel_ready & ~clear;
      second  = (state == HAVE_FIRST) & xfer;
      eq_now  = (sel_value == first_val);
      eq_sel  = second ? eq_now : eq_reg;
      done_n  = (state == SIGNAL) & hold_zero & ~clear;
      state_n = clear                          ? IDLE       :
                (state == IDLE && xfer)        ? HAVE_FIRST :
                second                         ? SIGNAL     :
                (state == SIGNAL && hold_zero) ? IDLE       : state;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         first_val  <= '0;
         eq_reg     <= 1'b0;
         match      <= 1'b0;
         not_match  <= 1'b0;
         pair_done  <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (state == IDLE && xfer)
            first_val <= sel_value;
         if (second) begin
            eq_reg <= eq_now;
            if (eq_now)
               hit_count <= SCORE_W'(sat_inc(32'(hit_count), SCORE_W));
            else
               miss_count <= SCORE_W'(sat_inc(32'(miss_count), SCORE_W));
         end
         match     <= (state_n == SIGNAL) &  eq_sel;
         not_match <= (state_n == SIGNAL) & ~eq_sel;
         pair_done <= done_n;
      end

endmodule

// File: doc/match_event_generator.md
Name: match_event_generator

Overview:
Producer side of the match/not_match interface consumed by the piezo tone block. Accepts two card selections per turn over a valid/ready handshake, compares them, and drives exactly one of match/not_match high for a fixed hold window. Also keeps saturating hit/miss counters for the score display. Sits between the selection/keypad logic and the sound generator.

Parameters:
VAL_W, 4, width of a card value
HOLD_CYCLES, 1000, cycles match/not_match stays high per turn; legal range 1..2^CNT_W-1
CNT_W, 20, width of hold counter
SCORE_W, 8, width of hit/miss counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort of current turn; counters kept
sel_valid  in  1  selection offered
sel_value  in  VAL_W  card value of offered selection
sel_ready  out  1  block can accept a selection this cycle
match  out  1  high for HOLD_CYCLES cycles when the pair is equal
not_match  out  1  high for HOLD_CYCLES cycles when the pair differs
busy  out  1  high in HAVE_FIRST and SIGNAL
pair_done  out  1  one-cycle pulse after the hold window ends
hit_count  out  SCORE_W  saturating number of matches
miss_count  out  SCORE_W  saturating number of mismatches

Behaviour:
- Reset (async, active-high) and any mid-operation assertion: state IDLE; match, not_match, busy, pair_done, hit_count, miss_count all 0; sel_ready 0 while rst is high, then 1 in IDLE; hold counter 0; first_val 0.
- Transfer occurs when sel_valid && sel_ready at a rising edge.
- sel_ready = 1 in IDLE and HAVE_FIRST; 0 in SIGNAL. Combinational from state only, with no dependence on sel_valid.
- IDLE: on transfer, latch sel_value into first_val and go to HAVE_FIRST.
- HAVE_FIRST: on transfer, register the comparison result (sel_value == first_val), load the hold counter with HOLD_CYCLES-1, and go to SIGNAL.
- In the same edge, increment hit_count or miss_count. Counters saturate at 2^SCORE_W-1.
- SIGNAL: match = eq_reg, not_match = ~eq_reg. Both are registered, so they assert the cycle after the second transfer.
  - Hold counter decrements each cycle.
  - When it reads 0, go to IDLE next edge, so the output is high for exactly HOLD_CYCLES cycles.
- pair_done: high for exactly the first cycle after SIGNAL exits normally, which is the first IDLE cycle. It is registered.
- Invariant: match and not_match are never high together. Both are 0 outside SIGNAL.
- clear: checked first, before any transfer in the same cycle.
  - Forces IDLE next edge from any state.
  - Drops match/not_match next cycle.
  - No pair_done.
  - A transfer offered in the same cycle is not accepted, because clear wins. sel_ready stays as computed, and the consumer must treat a clear cycle as non-transfer.
  - hit_count/miss_count are not changed by clear.
- Selecting the same value twice is a legal match; no card-identity checking is done here.
- sel_valid held across SIGNAL is stalled and accepted as the first selection of the next turn in the first IDLE cycle.
- Input latency: second transfer edge -> match/not_match high at the next cycle. First output cycle to last output cycle spans HOLD_CYCLES cycles.

Decomposition:
- Package match_pkg holds:
  - state typedef {IDLE, HAVE_FIRST, SIGNAL}, 2 bits
  - default constants HOLD_CYCLES_DEF=1000, VAL_W_DEF=4
  - helper function sat_inc(count)
- One sub-module is natural: hold_timer, a loadable down-counter with CNT_W width and load/value/zero ports.
- FSM, compare and score counters live in the top.

Test Plan:
All scenarios use HOLD_CYCLES=4.
- Match turn: select 3 then 3 back-to-back -> match high cycles N+1..N+4, not_match 0, pair_done pulse at N+5, hit_count 0->1, sel_ready low N+1..N+4.
- Mismatch turn: select 5 then 9 -> not_match high 4 cycles, match 0, miss_count 1, hit_count unchanged.
- Stall: hold sel_valid=1, value 2, during SIGNAL -> not accepted until the pair_done cycle. There it is accepted as first_val=2 and busy rises next cycle.
- Clear: clear after the first select -> IDLE, no outputs. Clear at the 2nd SIGNAL cycle -> match drops next cycle, no pair_done, hit_count keeps its increment.
- Reset mid-SIGNAL: assert rst asynchronously -> match, not_match, busy and counters go 0 immediately; after release a new turn works normally.
- Saturation: run 260 match turns with SCORE_W=8 -> hit_count stops at 255; match is still generated each turn.
